// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared types and constants for the AHB-lite fetch/load-store arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the transfer in flight
//   HSIZE_*     : AHB transfer size codes
//   HPROT_*     : protection codes for fetch and data accesses
package ahb_arb_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} arb_state_t;

   typedef enum logic {FETCH, LDST} owner_t;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [3:0] HPROT_FETCH = 4'b0010;
   localparam logic [3:0] HPROT_DATA  = 4'b0011;

endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: combinational slave decode for the instruction/data memory pair.
//   addr_i  : byte address to decode
//   hsel1_o : address falls in instruction memory (ROM_BASE, 2**ROM_AW bytes)
//   hsel2_o : address falls in data memory (RAM_BASE, 2**RAM_AW bytes)
//   miss_o  : address maps to neither slave
module ahb_addr_decode #(
   parameter logic [31:0] ROM_BASE = 32'h0000_0000,
   parameter int unsigned ROM_AW   = 12,
   parameter logic [31:0] RAM_BASE = 32'h1000_0000,
   parameter int unsigned RAM_AW   = 12
) (
   input  logic [31:0] addr_i,
   output logic        hsel1_o,
   output logic        hsel2_o,
   output logic        miss_o
);

   logic [31:0] rom_diff;
   logic [31:0] ram_diff;
   logic        rom_match;
   logic        ram_match;

   // Region match: all bits above the region size equal the base.
   assign rom_diff  = addr_i ^ ROM_BASE;
   assign ram_diff  = addr_i ^ RAM_BASE;
   assign rom_match = ((rom_diff >> ROM_AW) == 32'd0);
   assign ram_match = ((ram_diff >> RAM_AW) == 32'd0);

   // Instruction memory wins if the regions are ever configured to overlap,
   // so the selects stay one-hot.
   assign hsel1_o = rom_match;
   assign hsel2_o = ram_match & ~rom_match;
   assign miss_o  = ~rom_match & ~ram_match;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: AHB-lite front end sharing the instruction/data slave pair between the
// core's fetch port (if_*) and load/store port (ls_*).
//   clk, reset          : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request; if_gnt/if_rvalid/if_err pulses, if_rdata result
//   ls_req/ls_we/...    : load/store request; ls_gnt/ls_rvalid/ls_err pulses, ls_rdata result
//   HSEL1/HSEL2, haddr, hwrite, hwdata, hsize, hprot, is_signed : bus to the slave wrapper
//   instruction/load_out, hready_*/hresp_* : slave read data, ready and error
// Optional feature: define ARB_TIMEOUT_EN to abort a data phase that waits TIMEOUT_CYCLES
// cycles on hready; without it the arbiter waits indefinitely.
// All outputs are registered. A decode miss spends one silent cycle in ERR before the
// error pulse, so it completes with the same latency as a zero-wait transfer.
module ahb_bus_arbiter #(
   parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
   parameter int unsigned ROM_AW         = 12,
   parameter logic [31:0] RAM_BASE       = 32'h1000_0000,
   parameter int unsigned RAM_AW         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [2:0]  ls_size,
   input  logic        ls_signed,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        HSEL1,
   output logic        HSEL2,
   output logic [31:0] haddr,
   output logic        hwrite,
   output logic [31:0] hwdata,
   output logic [2:0]  hsize,
   output logic [3:0]  hprot,
   output logic        is_signed,
   input  logic [31:0] instruction,
   input  logic [31:0] load_out,
   input  logic        hready_inst,
   input  logic        hready_data,
   input  logic        hresp_inst,
   input  logic        hresp_data
);
   import ahb_arb_pkg::*;

   arb_state_t  state_q, state_d;
   owner_t      owner_q, owner_d, last_owner_q, last_owner_d;
   logic        err_phase_q, err_phase_d;
   logic [31:0] wdata_q, wdata_d;
   logic        hsel1_q, hsel1_d, hsel2_q, hsel2_d;
   logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
   logic        hwrite_q, hwrite_d, is_signed_q, is_signed_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [3:0]  hprot_q, hprot_d;
   logic        if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
   logic        ls_gnt_q, ls_gnt_d, ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
   logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

   logic        grant_ls, gnt, done_ok, done_err, bus_clr;
   logic [31:0] dec_addr, rd_word;
   logic        dec_hsel1, dec_hsel2, dec_miss, sel_hready, sel_hresp;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   // Contended IDLE: the port that did not win last time goes next.
   assign grant_ls = ls_req & (~if_req | (last_owner_q == FETCH));
   assign dec_addr = grant_ls ? ls_addr : if_addr;

   ahb_addr_decode #(
      .ROM_BASE (ROM_BASE),
      .ROM_AW   (ROM_AW),
      .RAM_BASE (RAM_BASE),
      .RAM_AW   (RAM_AW)
   ) u_decode (
      .addr_i  (dec_addr),
      .hsel1_o (dec_hsel1),
      .hsel2_o (dec_hsel2),
      .miss_o  (dec_miss)
   );

   assign sel_hready = hsel1_q ? hready_inst : hready_data;
   assign sel_hresp  = hsel1_q ? hresp_inst  : hresp_data;
   assign rd_word    = hwrite_q ? 32'd0 : (hsel1_q ? instruction : load_out);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      err_phase_d  = err_phase_q;
      wdata_d      = wdata_q;
      hsel1_d      = hsel1_q;
      hsel2_d      = hsel2_q;
      haddr_d      = haddr_q;
      hwrite_d     = hwrite_q;
      hwdata_d     = hwdata_q;
      hsize_d      = hsize_q;
      hprot_d      = hprot_q;
      is_signed_d  = is_signed_q;
      if_rdata_d   = if_rdata_q;
      ls_rdata_d   = ls_rdata_q;
      gnt          = 1'b0;
      done_ok      = 1'b0;
      done_err     = 1'b0;
      bus_clr      = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (if_req || ls_req) begin
               gnt          = 1'b1;
               owner_d      = grant_ls ? LDST : FETCH;
               last_owner_d = owner_d;
               wdata_d      = ls_wdata;
               if (dec_miss) begin
                  state_d     = ERR;
                  err_phase_d = 1'b0;
               end else begin
                  state_d     = ADDR;
                  hsel1_d     = dec_hsel1;
                  hsel2_d     = dec_hsel2;
                  haddr_d     = dec_addr;
                  hwrite_d    = grant_ls & ls_we;
                  hsize_d     = grant_ls ? ls_size : HSIZE_WORD;
                  hprot_d     = grant_ls ? HPROT_DATA : HPROT_FETCH;
                  is_signed_d = grant_ls & ls_signed;
               end
            end
         end
         ADDR: begin
            state_d  = DATA;
            hwdata_d = hwrite_q ? wdata_q : 32'd0;
`ifdef ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
         end
         DATA: begin
            if (sel_hready) begin
               bus_clr = 1'b1;
               state_d = IDLE;
               if (sel_hresp) begin
                  done_err = 1'b1;
               end else begin
                  done_ok = 1'b1;
                  if (owner_q == FETCH) if_rdata_d = rd_word;
                  else                  ls_rdata_d = rd_word;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               bus_clr  = 1'b1;
               done_err = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ERR: begin
            if (err_phase_q) begin
               done_err    = 1'b1;
               err_phase_d = 1'b0;
               state_d     = IDLE;
            end else begin
               err_phase_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus_clr) begin
         hsel1_d     = 1'b0;
         hsel2_d     = 1'b0;
         haddr_d     = 32'd0;
         hwrite_d    = 1'b0;
         hwdata_d    = 32'd0;
         hsize_d     = 3'd0;
         hprot_d     = 4'd0;
         is_signed_d = 1'b0;
      end

      if_gnt_d    = gnt & (owner_d == FETCH);
      ls_gnt_d    = gnt & (owner_d == LDST);
      if_rvalid_d = done_ok & (owner_q == FETCH);
      ls_rvalid_d = done_ok & (owner_q == LDST);
      if_err_d    = done_err & (owner_q == FETCH);
      ls_err_d    = done_err & (owner_q == LDST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= FETCH;
         last_owner_q <= FETCH;
         err_phase_q  <= 1'b0;
         wdata_q      <= 32'd0;
         hsel1_q      <= 1'b0;
         hsel2_q      <= 1'b0;
         haddr_q      <= 32'd0;
         hwrite_q     <= 1'b0;
         hwdata_q     <= 32'd0;
         hsize_q      <= 3'd0;
         hprot_q      <= 4'd0;
         is_signed_q  <= 1'b0;
         if_gnt_q     <= 1'b0;
         if_rvalid_q  <= 1'b0;
         if_err_q     <= 1'b0;
         ls_gnt_q     <= 1'b0;
         ls_rvalid_q  <= 1'b0;
         ls_err_q     <= 1'b0;
         if_rdata_q   <= 32'd0;
         ls_rdata_q   <= 32'd0;
`ifdef ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         err_phase_q  <= err_phase_d;
         wdata_q      <= wdata_d;
         hsel1_q      <= hsel1_d;
         hsel2_q      <= hsel2_d;
         haddr_q      <= haddr_d;
         hwrite_q     <= hwrite_d;
         hwdata_q     <= hwdata_d;
         hsize_q      <= hsize_d;
         hprot_q      <= hprot_d;
         is_signed_q  <= is_signed_d;
         if_gnt_q     <= if_gnt_d;
         if_rvalid_q  <= if_rvalid_d;
         if_err_q     <= if_err_d;
         ls_gnt_q     <= ls_gnt_d;
         ls_rvalid_q  <= ls_rvalid_d;
         ls_err_q     <= ls_err_d;
         if_rdata_q   <= if_rdata_d;
         ls_rdata_q   <= ls_rdata_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign ls_gnt    = ls_gnt_q;
   assign ls_rvalid = ls_rvalid_q;
   assign ls_err    = ls_err_q;
   assign ls_rdata  = ls_rdata_q;
   assign HSEL1     = hsel1_q;
   assign HSEL2     = hsel2_q;
   assign haddr     = haddr_q;
   assign hwrite    = hwrite_q;
   assign hwdata    = hwdata_q;
   assign hsize     = hsize_q;
   assign hprot     = hprot_q;
   assign is_signed = is_signed_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed bench for ahb_bus_arbiter. Requester pulses (gnt/rvalid/err)
// are checked by a scoreboard monitor against expectations queued when stimulus is issued;
// bus-side signals are checked inline at known cycles.
module tb_ahb_bus_arbiter;

   localparam int P_IF  = 0;
   localparam int P_LS  = 1;
   localparam int K_GNT = 0;
   localparam int K_RV  = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          port;
      int          kind;
      int          cyc;
      logic [31:0] data;
   } evt_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, ls_req, ls_we, ls_signed;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [2:0]  ls_size;
   logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
   logic [31:0] if_rdata, ls_rdata;
   logic        HSEL1, HSEL2, hwrite, is_signed;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] instruction, load_out;
   logic        hready_inst, hready_data, hresp_inst, hresp_data;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   evt_t sb_q[$];

   ahb_bus_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_gnt      (if_gnt),
      .if_rvalid   (if_rvalid),
      .if_rdata    (if_rdata),
      .if_err      (if_err),
      .ls_req      (ls_req),
      .ls_we       (ls_we),
      .ls_addr     (ls_addr),
      .ls_wdata    (ls_wdata),
      .ls_size     (ls_size),
      .ls_signed   (ls_signed),
      .ls_gnt      (ls_gnt),
      .ls_rvalid   (ls_rvalid),
      .ls_rdata    (ls_rdata),
      .ls_err      (ls_err),
      .HSEL1       (HSEL1),
      .HSEL2       (HSEL2),
      .haddr       (haddr),
      .hwrite      (hwrite),
      .hwdata      (hwdata),
      .hsize       (hsize),
      .hprot       (hprot),
      .is_signed   (is_signed),
      .instruction (instruction),
      .load_out    (load_out),
      .hready_inst (hready_inst),
      .hready_data (hready_data),
      .hresp_inst  (hresp_inst),
      .hresp_data  (hresp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push(input int port, input int kind, input int c, input logic [31:0] d);
      evt_t e;
      e.port = port;
      e.kind = kind;
      e.cyc  = c;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic see(input int port, input int kind, input logic [31:0] d);
      evt_t e;
      n_chk++;
      if (sb_q.size() == 0) begin
         $display("FAIL evt_unexpected: got port=%0d kind=%0d cyc=%0d, expected no event",
                  port, kind, cyc);
      end else begin
         e = sb_q.pop_front();
         if (e.port == port && e.kind == kind && e.cyc == cyc && (kind != K_RV || e.data == d))
            n_pass++;
         else
            $display("FAIL evt: got port=%0d kind=%0d cyc=%0d data=%h, expected port=%0d kind=%0d cyc=%0d data=%h",
                     port, kind, cyc, d, e.port, e.kind, e.cyc, e.data);
      end
   endtask

   // Monitor: every requester-side pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (if_gnt)    see(P_IF, K_GNT, 32'd0);
      if (if_rvalid) see(P_IF, K_RV, if_rdata);
      if (if_err)    see(P_IF, K_ERR, 32'd0);
      if (ls_gnt)    see(P_LS, K_GNT, 32'd0);
      if (ls_rvalid) see(P_LS, K_RV, ls_rdata);
      if (ls_err)    see(P_LS, K_ERR, 32'd0);
   end

   task automatic step_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise a request; g is the cycle its gnt pulse is expected in.
   task automatic issue(input bit to_ls, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz, input logic sg,
                        output int g);
      g = cyc + 1;
      if (to_ls) begin
         ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_size = sz; ls_signed = sg;
         push(P_LS, K_GNT, g, 32'd0);
      end else begin
         if_req = 1'b1; if_addr = a;
         push(P_IF, K_GNT, g, 32'd0);
      end
   endtask

   initial begin
      int g;
      int k;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_size = '0; ls_signed = 1'b0;
      instruction = '0; load_out = '0;
      hready_inst = 1'b1; hready_data = 1'b1; hresp_inst = 1'b0; hresp_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_hsel", {30'd0, HSEL1, HSEL2}, 32'd0);
      chk("rst_haddr", haddr, 32'd0);
      chk("rst_pulses", {26'd0, if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err}, 32'd0);
      chk("rst_rdata", if_rdata | ls_rdata, 32'd0);

      // Zero-wait fetch.
      instruction = 32'h1357_9BDF;
      issue(1'b0, 1'b0, 32'h0000_0004, 32'd0, 3'd0, 1'b0, g);
      push(P_IF, K_RV, g + 2, 32'h1357_9BDF);
      step_to(g);
      if_req = 1'b0;
      chk("f_hsel", {30'd0, HSEL1, HSEL2}, 32'd2);
      chk("f_haddr", haddr, 32'h0000_0004);
      chk("f_hprot", {28'd0, hprot}, 32'h2);
      chk("f_hsize", {29'd0, hsize}, 32'h2);
      chk("f_hwrite", {31'd0, hwrite}, 32'd0);
      step_to(g + 3);

      // Store with three wait states.
      hready_data = 1'b0;
      issue(1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 3'd2, 1'b0, g);
      push(P_LS, K_RV, g + 5, 32'd0);
      step_to(g);
      ls_req = 1'b0;
      chk("st_hsel", {30'd0, HSEL1, HSEL2}, 32'd1);
      step_to(g + 1);
      chk("st_hwdata", hwdata, 32'hDEAD_BEEF);
      chk("st_hwrite", {31'd0, hwrite}, 32'd1);
      step_to(g + 4);
      hready_data = 1'b1;
      step_to(g + 6);

      // Signed halfword load.
      load_out = 32'hCAFE_F00D;
      issue(1'b1, 1'b0, 32'h1000_0020, 32'd0, 3'd1, 1'b1, g);
      push(P_LS, K_RV, g + 2, 32'hCAFE_F00D);
      step_to(g);
      ls_req = 1'b0;
      chk("ld_attr", {24'd0, is_signed, hsize, hprot}, {24'd0, 1'b1, 3'd1, 4'b0011});
      step_to(g + 3);

      // Slave error on a load: err only, rdata kept.
      hresp_data = 1'b1;
      load_out = 32'h1111_2222;
      issue(1'b1, 1'b0, 32'h1000_0024, 32'd0, 3'd2, 1'b0, g);
      push(P_LS, K_ERR, g + 2, 32'd0);
      step_to(g);
      ls_req = 1'b0;
      step_to(g + 2);
      chk("lderr_rdata", ls_rdata, 32'hCAFE_F00D);
      hresp_data = 1'b0;
      step_to(g + 3);

      // Decode miss: no select, err two cycles after gnt.
      issue(1'b1, 1'b0, 32'h2000_0000, 32'd0, 3'd2, 1'b0, g);
      push(P_LS, K_ERR, g + 2, 32'd0);
      step_to(g);
      ls_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("miss_hsel", {30'd0, HSEL1, HSEL2}, 32'd0);
         step_to(g + i + 1);
      end

      // Both requesters held from reset: ls, if, ls.
      reset = 1'b1;
      step_to(cyc + 1);
      if_req = 1'b1; if_addr = 32'h0000_0008;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h1000_0030; ls_size = 3'd2; ls_signed = 1'b0;
      instruction = 32'hA5A5_A5A5;
      load_out = 32'h5A5A_5A5A;
      step_to(cyc + 1);
      reset = 1'b0;
      k = cyc;
      push(P_LS, K_GNT, k + 1, 32'd0);
      push(P_LS, K_RV, k + 3, 32'h5A5A_5A5A);
      push(P_IF, K_GNT, k + 4, 32'd0);
      push(P_IF, K_RV, k + 6, 32'hA5A5_A5A5);
      push(P_LS, K_GNT, k + 7, 32'd0);
      push(P_LS, K_RV, k + 9, 32'h5A5A_5A5A);
      step_to(k + 7);
      if_req = 1'b0;
      ls_req = 1'b0;
      step_to(k + 10);

      // Reset in the middle of a data phase drops the transfer silently.
      hready_data = 1'b0;
      issue(1'b1, 1'b0, 32'h1000_0040, 32'd0, 3'd2, 1'b1, g);
      step_to(g);
      ls_req = 1'b0;
      step_to(g + 1);
      reset = 1'b1;
      step_to(g + 2);
      chk("mrst_bus", {HSEL1, HSEL2, hwrite, is_signed, hsize, hprot} | haddr, 32'd0);
      chk("mrst_rdata", if_rdata | ls_rdata, 32'd0);
      reset = 1'b0;
      hready_data = 1'b1;
      step_to(g + 6);

`ifdef ARB_TIMEOUT_EN
      // Data phase stuck: err after exactly TIMEOUT_CYCLES data cycles.
      hready_data = 1'b0;
      issue(1'b1, 1'b0, 32'h1000_0044, 32'd0, 3'd2, 1'b0, g);
      push(P_LS, K_ERR, g + 17, 32'd0);
      step_to(g);
      ls_req = 1'b0;
      step_to(g + 17);
      chk("to_hsel", {30'd0, HSEL1, HSEL2}, 32'd0);
      hready_data = 1'b1;
      step_to(g + 19);
`endif

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
